// File: rtl/ext_pipe.sv
// Pipelined immediate / load-data extension unit with a registered output and one-entry skid buffer.
// Optional misaligned-halfword flag enabled by defining EXT_ERR_EN.
module ext_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int OFF_W = $clog2(OUT_W / 8)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [OUT_W-1:0] in_data,
   input  logic [OFF_W-1:0] in_off,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_err
);

   logic [IN_W-1:0]  imm;
   logic [OFF_W-1:0] half_off;
   logic [7:0]       byte_v;
   logic [15:0]      half_v;
   logic [OUT_W-1:0] res;

   logic             o_valid_q, o_valid_d;
   logic             s_valid_q, s_valid_d;
   logic [OUT_W-1:0] o_data_q, o_data_d;
   logic [OUT_W-1:0] s_data_q, s_data_d;
   logic             acc, pop;
   logic             o_from_s, o_from_in, s_from_in;

   always_comb begin
      imm      = in_data[IN_W-1:0];
      half_off = in_off;
      half_off[0] = 1'b0;
      byte_v   = 8'(in_data >> {in_off, 3'b000});
      half_v   = 16'(in_data >> {half_off, 3'b000});
      res      = '0;
      case (in_op)
         3'd0:    res = OUT_W'($signed(imm));
         3'd1:    res = OUT_W'(imm);
         3'd2:    res = OUT_W'(imm) << (OUT_W - IN_W);
         3'd3:    res = OUT_W'($signed(byte_v));
         3'd4:    res = OUT_W'(byte_v);
         3'd5:    res = OUT_W'($signed(half_v));
         3'd6:    res = OUT_W'(half_v);
         default: res = '0;
      endcase
   end

   assign in_ready  = !s_valid_q;
   assign out_valid = o_valid_q;
   assign out_data  = o_data_q;
   assign acc       = in_valid && in_ready;
   assign pop       = o_valid_q && out_ready;

   // Flush wins over both acceptance and pop; the skid drains into O before new work lands.
   always_comb begin
      o_valid_d = o_valid_q;
      s_valid_d = s_valid_q;
      o_from_s  = 1'b0;
      o_from_in = 1'b0;
      s_from_in = 1'b0;
      if (flush) begin
         o_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end else if (!o_valid_q || pop) begin
         if (s_valid_q) begin
            o_from_s  = 1'b1;
            o_valid_d = 1'b1;
            s_valid_d = 1'b0;
         end else begin
            o_from_in = acc;
            o_valid_d = acc;
         end
      end else if (acc) begin
         s_from_in = 1'b1;
         s_valid_d = 1'b1;
      end
   end

   always_comb begin
      o_data_d = o_data_q;
      s_data_d = s_data_q;
      if (o_from_s) begin
         o_data_d = s_data_q;
      end else if (o_from_in) begin
         o_data_d = res;
      end
      if (s_from_in) begin
         s_data_d = res;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_valid_q <= 1'b0;
         s_valid_q <= 1'b0;
         o_data_q  <= '0;
         s_data_q  <= '0;
      end else begin
         o_valid_q <= o_valid_d;
         s_valid_q <= s_valid_d;
         o_data_q  <= o_data_d;
         s_data_q  <= s_data_d;
      end
   end

`ifdef EXT_ERR_EN
   logic res_err;
   logic o_err_q, o_err_d;
   logic s_err_q, s_err_d;

   assign res_err = ((in_op == 3'd5) || (in_op == 3'd6)) && in_off[0];
   assign out_err = o_err_q;

   always_comb begin
      o_err_d = o_err_q;
      s_err_d = s_err_q;
      if (o_from_s) begin
         o_err_d = s_err_q;
      end else if (o_from_in) begin
         o_err_d = res_err;
      end
      if (s_from_in) begin
         s_err_d = res_err;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_err_q <= 1'b0;
         s_err_q <= 1'b0;
      end else begin
         o_err_q <= o_err_d;
         s_err_q <= s_err_d;
      end
   end
`else
   assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: expected {err,data} queued at acceptance, compared at each pop.
module tb_ext_pipe;

`ifdef EXT_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_err;
   logic [2:0]  in_op;
   logic [31:0] in_data, out_data;
   logic [1:0]  in_off;

   logic        w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_err;
   logic [2:0]  w_in_op;
   logic [63:0] w_in_data, w_out_data;
   logic [2:0]  w_in_off;

   logic [32:0] sb[$];
   logic [32:0] exp_v;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   ext_pipe dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
      .in_off(in_off), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_err(out_err)
   );

   ext_pipe #(.IN_W(8), .OUT_W(64)) dut64 (
      .clk(clk), .reset(reset), .flush(w_flush),
      .in_valid(w_in_valid), .in_ready(w_in_ready), .in_op(w_in_op), .in_data(w_in_data),
      .in_off(w_in_off), .out_valid(w_out_valid), .out_ready(w_out_ready),
      .out_data(w_out_data), .out_err(w_out_err)
   );

   always @(negedge clk) begin
      if (!reset && !flush && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got err=%0b data=%h, required no output", out_err,
                     out_data);
         end else begin
            exp_v = sb.pop_front();
            if ({out_err, out_data} !== exp_v) begin
               errors++;
               $display("FAIL result_order: got err=%0b data=%h, required err=%0b data=%h",
                        out_err, out_data, exp_v[32], exp_v[31:0]);
            end
         end
      end
   end

   task automatic send(input logic [2:0] op, input logic [31:0] d, input logic [1:0] off,
                       input logic [32:0] e);
      in_op = op;
      in_data = d;
      in_off = off;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 20 cycles, required acceptance");
      in_valid = 1'b0;
   endtask

   // Checks out_valid on the cycle right after acceptance (latency 1).
   task automatic send_lat(input logic [2:0] op, input logic [31:0] d, input logic [1:0] off,
                           input logic [32:0] e);
      send(op, d, off, e);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL latency op%0d: got out_valid=%b, required 1", op, out_valid);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      flush = 1'b0;
      in_valid = 1'b0;
      in_op = 3'd0;
      in_data = '0;
      in_off = '0;
      out_ready = 1'b1;
      w_flush = 1'b0;
      w_in_valid = 1'b0;
      w_in_op = 3'd0;
      w_in_data = '0;
      w_in_off = '0;
      w_out_ready = 1'b1;
      #1;
      checks++;
      if ({out_valid, in_ready, out_err, out_data} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL reset_state: got v=%b rdy=%b err=%b data=%h, required 0 1 0 00000000",
                  out_valid, in_ready, out_err, out_data);
      end
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_imm;
      out_ready = 1'b1;
      send_lat(3'd0, 32'h0000_8001, 2'd0, {1'b0, 32'hFFFF_8001});
      send_lat(3'd1, 32'hABCD_8001, 2'd0, {1'b0, 32'h0000_8001});
      send_lat(3'd2, 32'h0000_8001, 2'd0, {1'b0, 32'h8001_0000});
      send_lat(3'd7, 32'hFFFF_FFFF, 2'd3, {1'b0, 32'h0000_0000});
   endtask

   task automatic test_load;
      out_ready = 1'b1;
      send_lat(3'd3, 32'h80FF_7F01, 2'd0, {1'b0, 32'h0000_0001});
      send_lat(3'd3, 32'h80FF_7F01, 2'd1, {1'b0, 32'h0000_007F});
      send_lat(3'd3, 32'h80FF_7F01, 2'd2, {1'b0, 32'hFFFF_FFFF});
      send_lat(3'd3, 32'h80FF_7F01, 2'd3, {1'b0, 32'hFFFF_FF80});
      send_lat(3'd4, 32'h80FF_7F01, 2'd3, {1'b0, 32'h0000_0080});
      send_lat(3'd5, 32'h80FF_7F01, 2'd2, {1'b0, 32'hFFFF_80FF});
      send_lat(3'd6, 32'h80FF_7F01, 2'd0, {1'b0, 32'h0000_7F01});
   endtask

   task automatic test_misaligned;
      out_ready = 1'b1;
      send_lat(3'd5, 32'h1234_ABCD, 2'd1, {ERR_EN, 32'hFFFF_ABCD});
      send_lat(3'd6, 32'h1234_ABCD, 2'd3, {ERR_EN, 32'h0000_1234});
      send_lat(3'd5, 32'h1234_ABCD, 2'd2, {1'b0, 32'h0000_1234});
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      in_op = 3'd1;
      in_off = 2'd0;
      in_data = 32'h0000_1111;
      in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_accept_a: got in_ready=%b, required 1", in_ready);
      end
      sb.push_back({1'b0, 32'h0000_1111});
      @(posedge clk);
      #1;
      in_data = 32'h0000_2222;
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, out_data} !== {1'b1, 1'b1, 32'h0000_1111}) begin
         errors++;
         $display("FAIL bp_accept_b: got rdy=%b v=%b data=%h, required 1 1 00001111",
                  in_ready, out_valid, out_data);
      end
      sb.push_back({1'b0, 32'h0000_2222});
      @(posedge clk);
      #1;
      in_data = 32'h0000_3333;
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, out_data} !== {1'b0, 1'b1, 32'h0000_1111}) begin
         errors++;
         $display("FAIL bp_full_hold: got rdy=%b v=%b data=%h, required 0 1 00001111",
                  in_ready, out_valid, out_data);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain1: got in_ready=%b, required 0", in_ready);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid} !== 2'b11) begin
         errors++;
         $display("FAIL bp_drain2: got rdy=%b v=%b, required 1 1", in_ready, out_valid);
      end
      sb.push_back({1'b0, 32'h0000_3333});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid} !== 2'b11) begin
         errors++;
         $display("FAIL bp_drain3: got rdy=%b v=%b, required 1 1", in_ready, out_valid);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || sb.size() != 0) begin
         errors++;
         $display("FAIL bp_empty: got v=%b pending=%0d, required 0 0", out_valid, sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b1;
      in_op = 3'd1;
      in_off = 2'd0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 32'h0000_A000 + i;
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b1 || (i > 0 && out_valid !== 1'b1)) begin
            errors++;
            $display("FAIL b2b_%0d: got rdy=%b v=%b, required 1 1", i, in_ready, out_valid);
         end
         sb.push_back({1'b0, 32'h0000_A000 + 32'(i)});
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_flush;
      out_ready = 1'b0;
      send(3'd1, 32'h0000_0AAA, 2'd0, {1'b0, 32'h0000_0AAA});
      send(3'd1, 32'h0000_0BBB, 2'd0, {1'b0, 32'h0000_0BBB});
      in_data = 32'h0000_0CCC;
      in_valid = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid} !== 2'b01) begin
         errors++;
         $display("FAIL flush_pre: got rdy=%b v=%b, required 0 1", in_ready, out_valid);
      end
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL flush_post: got rdy=%b v=%b, required 1 0", in_ready, out_valid);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      in_data = 32'h0000_0DDD;
      in_valid = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_acc_drop: got out_valid=%b, required 0", out_valid);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_async_reset;
      out_ready = 1'b0;
      send(3'd1, 32'h0000_0555, 2'd0, {1'b0, 32'h0000_0555});
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({out_valid, in_ready, out_data} !== {1'b0, 1'b1, 32'h0}) begin
         errors++;
         $display("FAIL async_reset: got v=%b rdy=%b data=%h, required 0 1 00000000",
                  out_valid, in_ready, out_data);
      end
      sb.delete();
      @(posedge clk);
      #3;
      reset = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send_lat(3'd0, 32'h0000_8001, 2'd0, {1'b0, 32'hFFFF_8001});
   endtask

   task automatic test_wide;
      w_in_op = 3'd0;
      w_in_data = 64'h0000_0000_0000_0080;
      w_in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (w_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL wide_ready: got in_ready=%b, required 1", w_in_ready);
      end
      @(posedge clk);
      #1;
      w_in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({w_out_valid, w_out_err, w_out_data} !== {1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF80}) begin
         errors++;
         $display("FAIL wide_sext: got v=%b err=%b data=%h, required 1 0 ffffffffffffff80",
                  w_out_valid, w_out_err, w_out_data);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_imm();
      test_load();
      test_misaligned();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_wide();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending results, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
